// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Holds default geometry and the count-width function.
package pipe_reg_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready streaming bus used at both ends of the pipeline.
// master drives valid/data, slave drives ready.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8
);

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: data register plus valid bit.
// clr drops valid while data holds; en loads both from upstream.
module pipe_reg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             d_vld,
    input  logic [WIDTH-1:0] d_dat,
    output logic             q_vld,
    output logic [WIDTH-1:0] q_dat
);

    // Valid bit: flush beats load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_vld <= 1'b0;
        end else if (clr) begin
            q_vld <= 1'b0;
        end else if (en) begin
            q_vld <= d_vld;
        end
    end

    // Data register: holds across a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_dat <= '0;
        end else if (en && !clr) begin
            q_dat <= d_dat;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register pipeline with collapsing bubbles.
// Define PIPE_REG_CHAIN_COUNT_EN for a registered occupancy count.
module pipe_reg_chain
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_reg_chain_if.slave     in_bus,
    pipe_reg_chain_if.master    out_bus,
    output logic [CW-1:0]       count
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat   [DEPTH];
    logic [DEPTH-1:0] d_vld;
    logic [WIDTH-1:0] d_dat [DEPTH];
    logic [DEPTH-1:0] adv;

    // Stage i advances if any stage from i to the tail is empty
    // or the consumer is taking the tail word.
    always_comb begin
        logic acc;
        acc = out_bus.ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~vld[i];
            adv[i] = acc;
        end
    end

    assign in_bus.ready  = adv[0] & ~flush;
    assign out_bus.valid = vld[DEPTH-1] & ~flush;
    assign out_bus.data  = dat[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign d_vld[i] = in_bus.valid;
            assign d_dat[i] = in_bus.data;
        end else begin : g_body
            assign d_vld[i] = vld[i-1];
            assign d_dat[i] = dat[i-1];
        end

        pipe_reg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr   (flush),
            .en    (adv[i]),
            .d_vld (d_vld[i]),
            .d_dat (d_dat[i]),
            .q_vld (vld[i]),
            .q_dat (dat[i])
        );
    end

`ifdef PIPE_REG_CHAIN_COUNT_EN
    logic          in_hs;
    logic          out_hs;
    logic [CW-1:0] cnt;

    assign in_hs  = in_bus.valid & in_bus.ready;
    assign out_hs = out_bus.valid & out_bus.ready;

    // Occupancy: +1 on accept, -1 on emit, cleared by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (in_hs && !out_hs) begin
            cnt <= cnt + CW'(1);
        end else if (out_hs && !in_hs) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign count = cnt;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain against a
// position-based FIFO model of the elastic pipeline.
module tb_pipe_reg_chain;
    import pipe_reg_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int CW = clog2(D + 1);

    logic          clk;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;

    pipe_reg_chain_if #(.WIDTH(W)) in_if ();
    pipe_reg_chain_if #(.WIDTH(W)) out_if ();

    pipe_reg_chain #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_bus  (in_if),
        .out_bus (out_if),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: words oldest-first, each with its stage position.
    int mq_dat[$];
    int mq_pos[$];

    function automatic int m_count();
`ifdef PIPE_REG_CHAIN_COUNT_EN
        return mq_dat.size();
`else
        return 0;
`endif
    endfunction

    function automatic bit m_in_ready();
        return !flush && (mq_dat.size() < D || out_if.ready);
    endfunction

    function automatic bit m_out_valid();
        return !flush && mq_dat.size() > 0 && mq_pos[0] == D - 1;
    endfunction

    // Advance the model by one clock edge.
    task automatic model_edge();
        int nd[$];
        int np[$];
        int lim;
        int p;
        bit acc;
        if (flush) begin
            mq_dat.delete();
            mq_pos.delete();
            return;
        end
        acc = in_if.valid && m_in_ready();
        lim = D;
        for (int i = 0; i < mq_dat.size(); i++) begin
            p = mq_pos[i];
            if (i == 0 && p == D - 1 && out_if.ready) continue;
            if (p + 1 < lim) p = p + 1;
            nd.push_back(mq_dat[i]);
            np.push_back(p);
            lim = p;
        end
        if (acc) begin
            nd.push_back(int'(in_if.data));
            np.push_back(0);
        end
        mq_dat = nd;
        mq_pos = np;
    endtask

    // Model state follows clock edges and async reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq_dat.delete();
            mq_pos.delete();
        end else begin
            model_edge();
        end
    end

    // Per-cycle comparison of all DUT outputs with the model.
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            chk("in_ready", in_if.ready, m_in_ready());
            chk("out_valid", out_if.valid, m_out_valid());
            if (m_out_valid())
                chk("out_data", out_if.data, mq_dat[0]);
            chk("count", count, m_count());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] got[$];
    bit acc_hs;
    bit seen55;
    int exp_cnt;

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_count", count, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_if.ready, 1);
        cmp_en = 1'b1;
        tick();

        // Streaming 0x01..0x05 with consumer always ready.
        for (int j = 0; j < 8; j++) begin
            in_if.valid = (j < 5);
            in_if.data  = W'(j + 1);
            @(negedge clk);
            if (j >= 3) begin
                chk("stream_valid", out_if.valid, 1);
                chk("stream_data", out_if.data, j - 2);
            end else begin
                chk("stream_lat", out_if.valid, 0);
            end
            tick();
        end
        in_if.valid = 1'b0;
        repeat (4) tick();

        // Back-pressure: fourth word must stall.
        out_if.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_if.valid = 1'b1;
            in_if.data  = W'(8'hA0 + k);
            @(negedge clk);
            chk("bp_in_ready", in_if.ready, (k < 3) ? 1 : 0);
            if (k == 3) begin
`ifdef PIPE_REG_CHAIN_COUNT_EN
                exp_cnt = 3;
`else
                exp_cnt = 0;
`endif
                chk("bp_count", count, exp_cnt);
            end
            tick();
        end
        out_if.ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_if.valid && out_if.ready) got.push_back(out_if.data);
            acc_hs = in_if.valid && in_if.ready;
            tick();
            if (acc_hs) in_if.valid = 1'b0;
        end
        chk("bp_n_out", got.size(), 4);
        for (int n = 0; n < 4; n++) begin
            if (n < got.size()) chk("bp_order", got[n], 8'hA0 + n);
            else chk("bp_missing", 32'hFFFF_FFFF, 8'hA0 + n);
        end

        // Bubble collapse under stall.
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 8'h10;
        tick();
        in_if.valid = 1'b0;
        tick();
        tick();
        in_if.valid = 1'b1;
        in_if.data  = 8'h11;
        tick();
        in_if.valid = 1'b0;
        tick();
        @(negedge clk);
        chk("bub_valid", out_if.valid, 1);
        chk("bub_data", out_if.data, 8'h10);
        chk("bub_in_ready", in_if.ready, 1);
`ifdef PIPE_REG_CHAIN_COUNT_EN
        chk("bub_count", count, 2);
`else
        chk("bub_count", count, 0);
`endif
        tick();

        // Fill, then flush with a simultaneous input word.
        in_if.valid = 1'b1;
        in_if.data  = 8'h12;
        tick();
        in_if.data = 8'h55;
        flush      = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", in_if.ready, 0);
        chk("fl_out_valid", out_if.valid, 0);
        tick();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        @(negedge clk);
        chk("fl_after_valid", out_if.valid, 0);
        chk("fl_after_count", count, 0);
        out_if.ready = 1'b1;
        seen55 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (out_if.valid && out_if.data == 8'h55) seen55 = 1'b1;
        end
        chk("fl_no_55", seen55, 0);
        tick();

        // Asynchronous reset with two words in flight.
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 8'h21;
        tick();
        in_if.data = 8'h22;
        tick();
        in_if.valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mrst_valid", out_if.valid, 0);
        chk("mrst_data", out_if.data, 0);
        chk("mrst_count", count, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", in_if.ready, 1);
        tick();

        // Random traffic with occasional flushes.
        for (int n = 0; n < 3000; n++) begin
            in_if.valid  = ($urandom % 4) != 0;
            in_if.data   = W'($urandom);
            out_if.ready = ($urandom % 3) != 0;
            flush        = ($urandom % 25) == 0;
            tick();
        end
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data registers with per-stage valid bits and a valid/ready handshake at both ends. It is the general replacement for single D flip-flop stages wherever a bus must be delayed, retimed or back-pressured. It sits between producer and consumer blocks on datapath boundaries, and bubbles collapse under stall.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 3, number of register stages (≥1)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately on assertion, release synchronised externally
- flush  in  1  synchronous clear of all stage valid bits
- in_valid  in  1  producer has data
- in_data  in  WIDTH  producer data
- in_ready  out  1  pipeline accepts in_data this cycle
- out_valid  out  1  last stage holds data
- out_data  out  WIDTH  last-stage data
- out_ready  in  1  consumer accepts out_data this cycle
- count  out  clog2(DEPTH+1)  number of valid stages (see Configuration)

## Operation
- Stage i holds vld[i], dat[i]; stage 0 is the input, stage DEPTH-1 the output.
- out_valid = vld[DEPTH-1] & ~flush; out_data = dat[DEPTH-1].
- Advance rule: adv[DEPTH-1] = ~vld[DEPTH-1] | out_ready; adv[i] = ~vld[i] | adv[i+1] for i < DEPTH-1.
- in_ready = adv[0] & ~flush.
- On an edge where adv[i] is set: stage i loads from stage i-1 (stage 0 from in_data/in_valid). Where adv[i] is clear, stage i holds.
- Bubbles collapse: an empty stage always accepts from upstream, even while downstream is stalled.
- Input handshake = in_valid & in_ready; output handshake = out_valid & out_ready. Data is never dropped or duplicated except on flush/reset.
- flush: at the next edge all vld[] clear and dat[] hold. While flush is high, no handshake occurs at either end and in_data is ignored.
- Simultaneous flush and in_valid: flush wins and the input is not accepted.
- Order is preserved strictly (FIFO semantics, capacity DEPTH).

## Timing
- Reset: vld[] = 0, dat[] = 0. Hence out_valid = 0, out_data = 0, count = 0, and in_ready = 1 once flush is low.
- Reset mid-operation: all in-flight data is discarded immediately (asynchronous).
- Latency with out_ready held high: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles from presentation.
- Throughput: 1 word/cycle sustained when out_ready = 1.
- Full pipeline (all vld set) with out_ready = 0: in_ready = 0 combinationally.
- Full pipeline with out_ready = 1: in_ready = 1, so accept and emit occur on the same edge.
- in_ready depends combinationally on out_ready through the DEPTH-long adv chain; there is no registered ready.

## Configuration
- PIPE_REG_CHAIN_COUNT_EN defined: count is a registered occupancy counter. It increments on input handshake only, decrements on output handshake only, is unchanged when both or neither occur, and clears on flush and reset. It equals the popcount of vld[].
- Not defined: count is tied to 0 and no counter logic is generated.

## Structure
- Shared package pipe_reg_pkg: the count-width function clog2 and the default constants for WIDTH and DEPTH.
- Sub-module pipe_reg_stage: one stage with a WIDTH-bit data register, a valid bit, an enable (adv), an async active-low rst, and a sync clear of valid. It is instantiated DEPTH times by a generate loop.

## Test plan
- Reset and idle: assert rst low mid-stream with 2 words in flight -> out_valid = 0, out_data = 0, count = 0 immediately; in_ready = 1 after release.
- Streaming, DEPTH = 3, out_ready = 1: push 0x01..0x05 on consecutive cycles -> 0x01 at out_data 3 cycles after first presentation, then one word per cycle in order.
- Back-pressure: out_ready = 0, push 0xA0, 0xA1, 0xA2, 0xA3 -> first three accepted, in_ready = 0 for 0xA3, count = 3. Then raise out_ready -> 0xA0..0xA3 delivered in order with no loss.
- Bubble collapse: push 0x10, idle 2 cycles, push 0x11 with out_ready = 0 -> both resident in the last two stages, count = 2, in_ready = 1.
- Flush with simultaneous in_valid (0x55) on a full pipeline -> no handshake that cycle, next cycle out_valid = 0 and count = 0, and 0x55 never appears.
- Build without PIPE_REG_CHAIN_COUNT_EN and rerun the back-pressure test -> count stays 0, data behaviour identical.
